present_manager: RTL and testbench

- Owns the single on-screen power-up ("present") slot.
- Supplies the game state machine with a per-cycle random drop decision (presentChance) and the type of the present currently in play (presentType).
- Consumes presentDrop from the state machine: spawns a present at the hit position, makes it fall to the floor, keeps it for a fixed lifetime with an end-of-life blink, and clears it on collection (col_present) or when play mode ends.
- Drives position and visibility to the present drawing and collision logic.

---
 rtl/present_manager_if.sv | 26 ++
 rtl/present_manager.sv | 153 +++++++++++++++
 tb/tb_present_manager.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/present_manager_if.sv
// Signal bundle between the game state machine (master) and present_manager (slave).
interface present_manager_if;
  logic        startOfFrame;
  logic        secClk;
  logic        playmodeEnable;
  logic        presentDrop;
  logic [10:0] dropX;
  logic [10:0] dropY;
  logic        col_present;
  logic        presentChance;
  logic [1:0]  presentType;
  logic [10:0] presentX;
  logic [10:0] presentY;
  logic        presentActive;
  logic        presentVisible;

  modport master (
    output startOfFrame, secClk, playmodeEnable, presentDrop, dropX, dropY, col_present,
    input  presentChance, presentType, presentX, presentY, presentActive, presentVisible
  );

  modport slave (
    input  startOfFrame, secClk, playmodeEnable, presentDrop, dropX, dropY, col_present,
    output presentChance, presentType, presentX, presentY, presentActive, presentVisible
  );
endinterface

// File: rtl/present_manager.sv
// Single on-screen present slot: random drop decision, spawn, fall, floor lifetime with blink.
//
// state    | meaning
// IDLE     | slot empty, waiting for a drop request
// FALLING  | present visible, moving down each frame
// LANDED   | on the floor, steady, counting seconds
// BLINKING | on the floor, final seconds, visibility toggling
module present_manager #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          CHANCE_NUM     = 6,
  parameter int          FALL_SPEED     = 2,
  parameter int          FLOOR_Y        = 440,
  parameter int          X_MAX          = 639,
  parameter int          PRESENT_WIDTH  = 32,
  parameter int          PRESENT_HEIGHT = 32,
  parameter int          LIFETIME       = 6,
  parameter int          BLINK_TIME     = 2,
  parameter int          BLINK_FRAMES   = 8
) (
  input  logic             clk,
  input  logic             resetN,
  present_manager_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FALLING, LANDED, BLINKING} state_t;

  localparam int SEC_W   = $clog2(LIFETIME + 1);
  localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [10:0]        X_LIM    = 11'(X_MAX - PRESENT_WIDTH);
  localparam logic [10:0]        Y_LIM    = 11'(FLOOR_Y - PRESENT_HEIGHT);
  localparam logic [SEC_W-1:0]   LAND_TC  = SEC_W'(LIFETIME - BLINK_TIME - 1);
  localparam logic [SEC_W-1:0]   BLINK_TC = SEC_W'(BLINK_TIME - 1);
  localparam logic [FRAME_W-1:0] FRAME_TC = FRAME_W'(BLINK_FRAMES - 1);

  state_t               state, state_nxt;
  logic [15:0]          lfsr;
  logic                 chance_q;
  logic [SEC_W-1:0]     sec_cnt, sec_cnt_nxt;
  logic [FRAME_W-1:0]   frame_cnt, frame_cnt_nxt;
  logic [1:0]           type_q, type_nxt;
  logic [10:0]          x_q, x_nxt;
  logic [10:0]          y_q, y_nxt;
  logic                 blink_q, blink_nxt;
  logic [11:0]          y_step;

  // One bit wider than presentY so a near-floor step cannot wrap past the compare.
  assign y_step = {1'b0, y_q} + 12'(FALL_SPEED);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr     <= LFSR_SEED;
      chance_q <= 1'b0;
    end else begin
      lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      chance_q <= (lfsr[3:0] < 4'(CHANCE_NUM));
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      sec_cnt   <= '0;
      frame_cnt <= '0;
      type_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      blink_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sec_cnt   <= sec_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      type_q    <= type_nxt;
      x_q       <= x_nxt;
      y_q       <= y_nxt;
      blink_q   <= blink_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sec_cnt_nxt   = sec_cnt;
    frame_cnt_nxt = frame_cnt;
    type_nxt      = type_q;
    x_nxt         = x_q;
    y_nxt         = y_q;
    blink_nxt     = blink_q;

    if (!bus.playmodeEnable) begin
      state_nxt = IDLE;
    end else if (bus.col_present && (state != IDLE)) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.presentDrop) begin
            state_nxt = FALLING;
            type_nxt  = lfsr[5:4];
            x_nxt     = (bus.dropX > X_LIM) ? X_LIM : bus.dropX;
            y_nxt     = (bus.dropY > Y_LIM) ? Y_LIM : bus.dropY;
          end
        end
        FALLING: begin
          if (bus.startOfFrame) begin
            if (y_step >= {1'b0, Y_LIM}) begin
              y_nxt       = Y_LIM;
              sec_cnt_nxt = '0;
              state_nxt   = LANDED;
            end else begin
              y_nxt = y_step[10:0];
            end
          end
        end
        LANDED: begin
          if (bus.secClk) begin
            if (sec_cnt == LAND_TC) begin
              sec_cnt_nxt   = '0;
              frame_cnt_nxt = '0;
              blink_nxt     = 1'b1;
              state_nxt     = BLINKING;
            end else begin
              sec_cnt_nxt = sec_cnt + 1'b1;
            end
          end
        end
        BLINKING: begin
          if (bus.startOfFrame) begin
            if (frame_cnt == FRAME_TC) begin
              frame_cnt_nxt = '0;
              blink_nxt     = ~blink_q;
            end else begin
              frame_cnt_nxt = frame_cnt + 1'b1;
            end
          end
          if (bus.secClk) begin
            if (sec_cnt == BLINK_TC) state_nxt = IDLE;
            else                     sec_cnt_nxt = sec_cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.presentChance  = chance_q;
  assign bus.presentType    = type_q;
  assign bus.presentX       = x_q;
  assign bus.presentY       = y_q;
  assign bus.presentActive  = (state != IDLE);
  assign bus.presentVisible = (state == FALLING) || (state == LANDED) ||
                              ((state == BLINKING) && blink_q);

endmodule

// File: tb/tb_present_manager.sv
// Bench for present_manager: spawn-clamp vector table, directed lifetime sequences, random run vs. reference model.
module tb_present_manager;
  localparam int X_LIM = 607;
  localparam int Y_LIM = 408;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  present_manager_if bus ();

  present_manager dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: slot described by occupancy, fall position and time spent on the floor.
  logic [15:0] m_lfsr;
  logic        m_chance;
  logic        m_occ;
  logic        m_floor;
  int          m_secs;
  int          m_frames;
  logic [1:0]  m_type;
  int          m_x;
  int          m_y;

  typedef struct {
    int dx;
    int dy;
    int ex;
    int ey;
  } spawn_vec_t;

  spawn_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_visible();
    if (!m_occ) return 1'b0;
    if (!m_floor || m_secs < 4) return 1'b1;
    return ((m_frames / 8) % 2) == 0;
  endfunction

  task automatic model_step();
    logic [15:0] l;
    int dx, dy;
    l        = m_lfsr;
    m_chance = (int'(l[3:0]) < 6);
    m_lfsr   = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    dx = int'(bus.dropX);
    dy = int'(bus.dropY);
    if (!bus.playmodeEnable) begin
      m_occ = 1'b0;
    end else if (m_occ && bus.col_present) begin
      m_occ = 1'b0;
    end else if (!m_occ) begin
      if (bus.presentDrop) begin
        m_occ   = 1'b1;
        m_floor = 1'b0;
        m_type  = l[5:4];
        m_x     = (dx > X_LIM) ? X_LIM : dx;
        m_y     = (dy > Y_LIM) ? Y_LIM : dy;
      end
    end else if (!m_floor) begin
      if (bus.startOfFrame) begin
        if (m_y + 2 >= Y_LIM) begin
          m_y      = Y_LIM;
          m_floor  = 1'b1;
          m_secs   = 0;
          m_frames = 0;
        end else begin
          m_y = m_y + 2;
        end
      end
    end else begin
      if (m_secs >= 4 && bus.startOfFrame) m_frames++;
      if (bus.secClk) begin
        m_secs++;
        if (m_secs >= 6) m_occ = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("chance",  32'(bus.presentChance),  32'(m_chance));
    check("type",    32'(bus.presentType),    32'(m_type));
    check("x",       32'(bus.presentX),       32'(m_x));
    check("y",       32'(bus.presentY),       32'(m_y));
    check("active",  32'(bus.presentActive),  32'(m_occ));
    check("visible", 32'(bus.presentVisible), 32'(m_visible()));
  endtask

  task automatic clear_pulses();
    bus.startOfFrame = 1'b0;
    bus.secClk       = 1'b0;
    bus.presentDrop  = 1'b0;
    bus.col_present  = 1'b0;
  endtask

  task automatic spawn(input int dx, input int dy);
    bus.presentDrop = 1'b1;
    bus.dropX       = 11'(dx);
    bus.dropY       = 11'(dy);
    tick();
    bus.presentDrop = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [1:0] saved_type;
    bit found;

    clear_pulses();
    bus.playmodeEnable = 1'b0;
    bus.dropX = '0;
    bus.dropY = '0;
    m_lfsr = 16'hACE1; m_chance = 1'b0; m_occ = 1'b0; m_floor = 1'b0;
    m_secs = 0; m_frames = 0; m_type = 2'b00; m_x = 0; m_y = 0;

    vecs[0] = '{620, 100, 607, 100};
    vecs[1] = '{0, 0, 0, 0};
    vecs[2] = '{607, 408, 607, 408};
    vecs[3] = '{608, 409, 607, 408};
    vecs[4] = '{2047, 2047, 607, 408};
    vecs[5] = '{300, 407, 300, 407};

    // Reset held for three cycles
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_chance",  32'(bus.presentChance),  0);
      check("rst_type",    32'(bus.presentType),    0);
      check("rst_x",       32'(bus.presentX),       0);
      check("rst_y",       32'(bus.presentY),       0);
      check("rst_active",  32'(bus.presentActive),  0);
      check("rst_visible", 32'(bus.presentVisible), 0);
      check("rst_lfsr",    32'(dut.lfsr),           32'h0000ACE1);
    end
    resetN = 1'b1;

    // Drop-probability rate with play mode off
    cnt = 0;
    repeat (4096) begin
      tick();
      if (bus.presentChance) cnt++;
    end
    check("chance_rate_in_window", 32'((cnt >= 1414) && (cnt <= 1658)), 1);

    // Spawn clamping table
    bus.playmodeEnable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      spawn(vecs[i].dx, vecs[i].dy);
      check("tbl_x",      32'(bus.presentX),      32'(vecs[i].ex));
      check("tbl_y",      32'(bus.presentY),      32'(vecs[i].ey));
      check("tbl_active", 32'(bus.presentActive), 1);
      bus.col_present = 1'b1;
      tick();
      bus.col_present = 1'b0;
      check("tbl_collect", 32'(bus.presentActive), 0);
    end

    // Full life: fall 154 frames, 4 s steady, 2 s blinking
    spawn(620, 100);
    bus.startOfFrame = 1'b1;
    repeat (153) tick();
    check("fall_y_153", 32'(bus.presentY), 406);
    tick();
    check("fall_y_154", 32'(bus.presentY), 408);
    for (int p = 1; p <= 6; p++) begin
      for (int i = 1; i <= 39; i++) begin
        tick();
        if (p <= 4) check("life_steady_vis", 32'(bus.presentVisible), 1);
        if (p == 5) check("life_blink_vis", 32'(bus.presentVisible), 32'(((i / 8) % 2) == 0));
      end
      bus.secClk = 1'b1;
      tick();
      bus.secClk = 1'b0;
      if (p == 4) check("blink_entry_vis", 32'(bus.presentVisible), 1);
      if (p < 6)  check("life_active", 32'(bus.presentActive), 1);
    end
    check("life_end_active",  32'(bus.presentActive),  0);
    check("life_end_visible", 32'(bus.presentVisible), 0);
    bus.startOfFrame = 1'b0;

    // Collection while falling with type 2'b10
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      spawn(200, 50);
      if (m_type == 2'b10) begin
        found = 1'b1;
      end else begin
        bus.col_present = 1'b1;
        tick();
        bus.col_present = 1'b0;
      end
    end
    check("type10_found", 32'(found), 1);
    bus.col_present = 1'b1;
    check("col_type_during", 32'(bus.presentType), 2);
    tick();
    bus.col_present = 1'b0;
    check("col_type_after",    32'(bus.presentType),    2);
    check("col_active_after",  32'(bus.presentActive),  0);
    check("col_visible_after", 32'(bus.presentVisible), 0);
    tick();
    check("col_type_hold", 32'(bus.presentType), 2);

    // Second drop while occupied is ignored; drop+collect loses the drop
    spawn(100, 50);
    saved_type = m_type;
    repeat (3) tick();
    spawn(500, 300);
    check("redrop_x",    32'(bus.presentX),    100);
    check("redrop_y",    32'(bus.presentY),    50);
    check("redrop_type", 32'(bus.presentType), 32'(saved_type));
    bus.presentDrop = 1'b1;
    bus.col_present = 1'b1;
    tick();
    clear_pulses();
    check("drop_col_active", 32'(bus.presentActive), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("drop_col_no_respawn", 32'(bus.presentActive), 0);
    end

    // Play mode dropped mid-blink, then restored without a drop
    spawn(10, 408);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    repeat (4) begin
      bus.secClk = 1'b1;
      tick();
      bus.secClk = 1'b0;
      tick();
    end
    bus.startOfFrame = 1'b1;
    repeat (10) tick();
    bus.startOfFrame = 1'b0;
    check("pm_blinking_active", 32'(bus.presentActive), 1);
    bus.playmodeEnable = 1'b0;
    tick();
    check("pm_off_active",  32'(bus.presentActive),  0);
    check("pm_off_visible", 32'(bus.presentVisible), 0);
    bus.playmodeEnable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pm_back_idle", 32'(bus.presentActive), 0);
    end

    // Random traffic against the model
    for (int i = 0; i < 20000; i++) begin
      bus.playmodeEnable = ($urandom_range(999) != 0);
      bus.presentDrop    = ($urandom_range(63) == 0);
      bus.col_present    = ($urandom_range(999) == 0);
      bus.startOfFrame   = ($urandom_range(3) == 0);
      bus.secClk         = ($urandom_range(15) == 0);
      bus.dropX          = 11'($urandom_range(2047));
      bus.dropY          = 11'($urandom_range(2047));
      tick();
    end
    clear_pulses();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
